// File: rtl/cbus_ram_pkg.sv
// cbus_ram_pkg -- shared CBus types for the on-chip RAM responder and its
// helpers (request/response structs, responder state encoding, legal burst
// lengths).
// Configuration macro: CBUS_RAM_DELAY_EN adds the WAIT state to the encoding.
package cbus_ram_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

`ifdef CBUS_RAM_DELAY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } cbus_ram_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd2
  } cbus_ram_state_t;
`endif

  // len field encodings: beat count is len+1
  localparam logic [3:0] CBUS_LEN_1  = 4'd0;
  localparam logic [3:0] CBUS_LEN_2  = 4'd1;
  localparam logic [3:0] CBUS_LEN_4  = 4'd3;
  localparam logic [3:0] CBUS_LEN_8  = 4'd7;
  localparam logic [3:0] CBUS_LEN_16 = 4'd15;

endpackage

// File: rtl/cbus_burst_addr.sv
// cbus_burst_addr -- wrapping burst word-index generator.
// Ports:
//   base  : word index latched from the first request address
//   len   : burst length field (len+1 beats, power of two)
//   count : current beat number
//   index : word index of this beat, wrapping inside the len+1 aligned block
module cbus_burst_addr #(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        len,
  input  logic [3:0]        count,
  output logic [ADDR_W-1:0] index
);

  logic [ADDR_W-1:0] mask;

  // len is 2^n-1, so it doubles as the in-block offset mask: upper bits stay
  // fixed at the block base, low bits advance and wrap.
  always_comb begin
    mask  = ADDR_W'(len);
    index = (base & ~mask) | ((base + ADDR_W'(count)) & mask);
  end

endmodule

// File: rtl/cbus_ram.sv
// cbus_ram -- single-ported word RAM acting as the CBus responder.
// Ports:
//   clk    : clock, all state on rising edge
//   resetn : synchronous active-low reset (memory contents are kept)
//   creq   : initiator request (valid, is_write, size, addr, strobe, data, len)
//   cresp  : responder reply (ready, last, data)
// Configuration macro: CBUS_RAM_DELAY_EN inserts DELAY wait cycles before
// the first beat of every transaction.
//
// state | meaning
// IDLE  | no transaction; accept a request when creq.valid
// WAIT  | first-beat delay, counting dly_q down to zero (macro only)
// BURST | one beat per cycle, ready=1, leave after beat counter==len
module cbus_ram
  import cbus_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int DELAY      = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
    $error("cbus_ram: DELAY must be within 1..15");
  end

  cbus_ram_state_t       state, state_nxt;
  logic [DEPTH_LOG2-1:0] base_q;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            len_q;
  logic [3:0]            cnt_q;
  logic                  is_write_q;
  logic                  accept;
  logic                  beat;
  logic [31:0]           mem [2**DEPTH_LOG2];
`ifdef CBUS_RAM_DELAY_EN
  logic [3:0]            dly_q;
`endif

  // size, byte offset and upper address bits carry no meaning for this RAM
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:DEPTH_LOG2+2]};

  cbus_burst_addr #(.ADDR_W(DEPTH_LOG2)) u_burst_addr (
    .base  (base_q),
    .len   (len_q),
    .count (cnt_q),
    .index (word_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    beat      = 1'b0;
    cresp     = '0;
    case (state)
      IDLE: begin
        if (creq.valid) begin
          accept = 1'b1;
`ifdef CBUS_RAM_DELAY_EN
          state_nxt = WAIT;
`else
          state_nxt = BURST;
`endif
        end
      end
`ifdef CBUS_RAM_DELAY_EN
      WAIT: begin
        if (dly_q == 4'd0) state_nxt = BURST;
      end
`endif
      BURST: begin
        beat        = 1'b1;
        cresp.ready = 1'b1;
        cresp.last  = (cnt_q == len_q);
        if (!is_write_q) cresp.data = mem[word_idx];
        if (cnt_q == len_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_q     <= '0;
      len_q      <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
`ifdef CBUS_RAM_DELAY_EN
      dly_q      <= '0;
`endif
    end else if (accept) begin
      base_q     <= creq.addr[DEPTH_LOG2+1:2];
      len_q      <= creq.len;
      is_write_q <= creq.is_write;
      cnt_q      <= '0;
`ifdef CBUS_RAM_DELAY_EN
      // WAIT lasts dly_q+1 cycles, so load one less than the delay
      dly_q      <= 4'(DELAY - 1);
`endif
    end else begin
`ifdef CBUS_RAM_DELAY_EN
      if (state == WAIT && dly_q != 4'd0) dly_q <= dly_q - 4'd1;
`endif
      if (beat && cnt_q != len_q) cnt_q <= cnt_q + 4'd1;
    end
  end

  // No reset on the array; a reset edge must also suppress a pending beat.
  always_ff @(posedge clk) begin
    if (resetn && beat && is_write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (creq.strobe[b]) mem[word_idx][8*b +: 8] <= creq.data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/cbus_ram.md
CBUS_RAM -- requirements
Module: cbus_ram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning word-array depth is 2^DEPTH_LOG2 32-bit words (16 KiB).
REQ-002 SHALL have parameter DELAY, default 3, meaning wait cycles inserted before the first beat when CBUS_RAM_DELAY_EN is defined; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port creq, input, cbus_req_t, the initiator request: valid, is_write, size, addr, strobe, data, len.
REQ-006 SHALL have port cresp, output, cbus_resp_t, the responder reply: ready, last, data.

Function
REQ-007 SHALL act as the CBus responder (memory side) to the CPU's CBus initiator; one transaction in flight at a time.
REQ-008 SHALL implement FSM states IDLE, WAIT, BURST; WAIT exists only with CBUS_RAM_DELAY_EN.
REQ-009 In IDLE with creq.valid=1, SHALL latch addr, len and is_write, clear the beat counter, and move to BURST (WAIT if the macro is defined).
REQ-010 In IDLE, SHALL drive cresp.ready=0 and cresp.last=0.
REQ-011 First-beat latency SHALL be: valid sampled in IDLE at cycle T -> ready=1 at T+1 (T+1+DELAY with the macro).
REQ-012 In BURST, SHALL assert cresp.ready=1 every cycle; every BURST cycle completes one beat; no back-pressure within a burst.
REQ-013 Beat count SHALL be len+1; legal len values are 0, 1, 3, 7, 15; cresp.last=1 only on the beat where counter==len.
REQ-014 Beat word index SHALL be base index plus counter, wrapping within the (len+1)-word aligned block; e.g. len=3, base word 0x6 -> 6,7,4,5.
REQ-015 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits are ignored, so out-of-range addresses alias; addr[1:0] and size are ignored.
REQ-016 On a read beat, cresp.data SHALL be the combinational read of the current beat word; outside BURST, or on a write, cresp.data SHALL be 0.
REQ-017 On a write beat, SHALL update only the byte lanes of the current word whose creq.strobe bit is 1, using creq.data of that cycle.
REQ-018 A read of a word in the cycle after a write to it SHALL return the updated value.
REQ-019 After the last beat (ready=1, last=1), SHALL return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-020 creq.valid falling to 0 mid-burst is a protocol violation; behaviour is unspecified except that no bytes outside the burst block are written.

Reset
REQ-021 While resetn=0 at a clock edge, SHALL enter IDLE, clear the counter and latched fields, and drive ready=0, last=0, data=0 from the next cycle.
REQ-022 Reset during WAIT or BURST SHALL abort the transaction; beats already written stay written; no further writes occur.
REQ-023 The memory array SHALL NOT be cleared by reset; power-up contents are zero in simulation.

Configuration
REQ-024 Macro CBUS_RAM_DELAY_EN defined: SHALL add WAIT, which holds ready=0 for exactly DELAY cycles via a down-counter, then enters BURST.
REQ-025 Macro CBUS_RAM_DELAY_EN undefined: SHALL omit WAIT and the delay counter entirely; IDLE goes directly to BURST.

Structure
REQ-026 The state enum cbus_ram_state_t and the legal len encodings SHALL live in the shared common package beside cbus_req_t and cbus_resp_t.
REQ-027 Wrap-address generation SHALL be the sub-module cbus_burst_addr (base index, len, counter -> word index), reused later by cache refill logic.

Verification
REQ-028 Single read: preload word 0x10 = 0xDEADBEEF; addr=0x40, len=0, no macro -> ready=1 at T+1 with last=1 and data=0xDEADBEEF.
REQ-029 Partial write: word 0x10 = 0xDEADBEEF; write addr=0x40, strobe=4'b0011, data=0x12345678 -> readback 0xDEAD5678.
REQ-030 Wrap burst: words 4..7 = 0xA0..0xA3; read addr=0x18, len=3 -> data 0xA2,0xA3,0xA0,0xA1 on consecutive cycles, last on the 4th beat only.
REQ-031 Delay: macro defined, DELAY=3; read len=7 -> ready=0 for T+1..T+3, then 8 back-to-back beats with ready=1 from T+4 to T+11.
REQ-032 Mid-burst reset: write len=15 to words 0..15 with data=index; resetn=0 after beat 5 -> words 0..5 updated, 6..15 unchanged, IDLE next cycle.
REQ-033 Aliasing with back-to-back requests: write addr=0x40 then read addr=0x4040 (DEPTH_LOG2=12) -> returns the written word; second request starts the cycle after last.
